fetch_sequencer: RTL and testbench

- Control FSM that sequences instruction fetch for the 16-bit custom processor.
- Owns the program counter and drives the instruction ROM request/acknowledge handshake.
- Generates the load enable for the instruction register and presents each captured instruction to the execute stage with a valid/ready handshake.
- Handles branch redirect and halt-opcode detection.

---
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundles the instruction-ROM request/acknowledge bus and
// the execute-stage valid/ready handshake driven by the fetch sequencer.
// master = sequencer side, slave = ROM / execute side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_req;
  logic              rom_ack;
  logic [15:0]       rom_data;
  logic              ir_load;
  logic              instr_valid;
  logic              exec_ready;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;

  modport master (
    output rom_addr, rom_req, ir_load, instr_valid,
    input  rom_ack, rom_data, exec_ready, branch_taken, branch_target
  );

  modport slave (
    input  rom_addr, rom_req, ir_load, instr_valid,
    output rom_ack, rom_data, exec_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM that owns the program counter, requests each
// instruction from the ROM, pulses the instruction-register load and hands the
// captured instruction to the execute stage. Stops on the HALT_OP opcode.
// Optional macro FETCH_SEQ_TIMEOUT_EN adds a ROM-acknowledge watchdog that
// raises a sticky fault and halts; without it fault is tied low.
module fetch_sequencer #(
  parameter int         ADDR_W  = 8,
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter int         TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  fetch_sequencer_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t state;
  state_t state_next;
  logic   ack_fire;
  logic   issue_fire;
  logic   restart;
  logic   timeout_hit;

  // rom_req is exactly "in FETCH", so an ack only counts while fetching
  assign ack_fire   = (state == FETCH) && bus.rom_ack;
  assign issue_fire = (state == ISSUE) && bus.exec_ready;
  assign restart    = start && ((state == IDLE) || (state == HALT));

`ifdef FETCH_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // the wait that would bring the count up to TIMEOUT is the one that trips
  assign timeout_hit = (state == FETCH) && !bus.rom_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  // count unacknowledged request cycles; held at zero outside FETCH
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      wait_cnt <= '0;
    else if (state != FETCH)
      wait_cnt <= '0;
    else if (!bus.rom_ack)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // sticky fault flag, cleared only by reset or a restart
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      fault <= 1'b0;
    else if (timeout_hit)
      fault <= 1'b1;
    else if (restart)
      fault <= 1'b0;
  end
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_next;
  end

  // next-state selection
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH: begin
        if (ack_fire)
          state_next = (bus.rom_data[15:12] == HALT_OP) ? HALT : ISSUE;
        else if (timeout_hit)
          state_next = HALT;
      end
      ISSUE:   if (bus.exec_ready) state_next = FETCH;
      HALT:    if (start) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // outputs decoded from the registered state, plus the same-cycle IR load
  always_comb begin
    bus.rom_req     = (state == FETCH);
    bus.rom_addr    = pc;
    bus.ir_load     = ack_fire;
    bus.instr_valid = (state == ISSUE);
    halted          = (state == HALT);
  end

  // program counter: zero while idle, step on ack, redirect on accepted branch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      pc <= '0;
    else if (state == IDLE)
      pc <= '0;
    else if (ack_fire)
      pc <= pc + 1'b1;
    else if (issue_fire && bus.branch_taken)
      pc <= bus.branch_target;
    else if (restart)
      pc <= '0;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: drives fetch_sequencer with directed and randomized ROM
// latency, execute backpressure, branches and restarts, and compares every
// cycle against a phase-level reference model of the instruction stream.
module tb_fetch_sequencer;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              fault;

  fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_sequencer #(
    .ADDR_W (ADDR_W),
    .HALT_OP(4'hF),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .bus   (bus.master),
    .pc    (pc),
    .halted(halted),
    .fault (fault)
  );

  // free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // reference model: what the sequencer is doing (0 idle, 1 fetching,
  // 2 issuing, 3 halted), which address it must fetch next, ROM latency left
  logic [15:0]       rom [256];
  int                phase;
  logic [ADDR_W-1:0] exp_addr;
  int                wait_left;
  int                cycle;
  int                last_load;
  bit                check_spacing;
  int                load_count;
  int                valid_count;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected)
      passes++;
    else
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
  endtask

  function automatic int pickWait(input int wait_cfg);
    return (wait_cfg < 0) ? int'($urandom_range(0, 4)) : wait_cfg;
  endfunction

  task automatic modelReset();
    phase     = 0;
    exp_addr  = '0;
    wait_left = 0;
  endtask

  task automatic applyReset();
    rstn              = 1'b0;
    start             = 1'b0;
    bus.rom_ack       = 1'b0;
    bus.rom_data      = '0;
    bus.exec_ready    = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    modelReset();
  endtask

  // one clock of stimulus, checked against the model, then the model advances
  task automatic applyStimulus(input bit start_in, input int wait_cfg,
                               input bit rand_exec);
    @(negedge clk);
    cycle++;
    start       = start_in;
    bus.rom_ack = (phase == 1) && (wait_left == 0);
    if (phase == 1 && wait_left > 0) wait_left--;
    bus.rom_data      = bus.rom_ack ? rom[exp_addr] : 16'($urandom);
    bus.exec_ready    = rand_exec ? ($urandom_range(0, 2) != 0) : 1'b1;
    bus.branch_taken  = rand_exec ? ($urandom_range(0, 2) == 0) : 1'b0;
    bus.branch_target = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    #1;
    checkOutput("rom_req", bus.rom_req, phase == 1);
    if (phase == 1) checkOutput("rom_addr", bus.rom_addr, exp_addr);
    checkOutput("ir_load", bus.ir_load, bus.rom_ack);
    checkOutput("instr_valid", bus.instr_valid, phase == 2);
    checkOutput("halted", halted, phase == 3);
    checkOutput("pc", pc, exp_addr);
    checkOutput("fault", fault, 0);
    if (bus.ir_load) load_count++;
    if (bus.instr_valid) valid_count++;
    case (phase)
      0, 3: if (start_in) begin
        phase     = 1;
        exp_addr  = '0;
        wait_left = pickWait(wait_cfg);
      end
      1: if (bus.rom_ack) begin
        if (check_spacing && last_load >= 0)
          checkOutput("spacing", cycle - last_load, 2);
        last_load = cycle;
        phase     = (rom[exp_addr][15:12] == 4'hF) ? 3 : 2;
        exp_addr  = exp_addr + 8'd1;
      end
      2: if (bus.exec_ready) begin
        if (bus.branch_taken) exp_addr = bus.branch_target;
        phase     = 1;
        wait_left = pickWait(wait_cfg);
      end
      default: ;
    endcase
  endtask

  initial begin
    cycle = 0;
    modelReset();
    rstn              = 1'b0;
    start             = 1'b0;
    bus.rom_ack       = 1'b0;
    bus.rom_data      = '0;
    bus.exec_ready    = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    #1;
    checkOutput("reset_rom_req", bus.rom_req, 0);
    checkOutput("reset_ir_load", bus.ir_load, 0);
    checkOutput("reset_valid", bus.instr_valid, 0);
    checkOutput("reset_halted", halted, 0);
    checkOutput("reset_fault", fault, 0);
    checkOutput("reset_pc", pc, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // straight-line program ending in a halt, zero-wait ROM, always ready
    for (int i = 0; i < 256; i++) rom[i] = {4'h1, 12'($urandom)};
    rom[0] = 16'h1234;
    rom[1] = 16'h2345;
    rom[2] = 16'h3456;
    rom[3] = 16'hF000;
    check_spacing = 1'b1;
    last_load     = -1;
    load_count    = 0;
    valid_count   = 0;
    applyStimulus(1'b1, 0, 1'b0);
    repeat (10) applyStimulus(1'b0, 0, 1'b0);
    check_spacing = 1'b0;
    checkOutput("straight_loads", load_count, 4);
    checkOutput("straight_valids", valid_count, 3);
    checkOutput("straight_halted", halted, 1);
    checkOutput("straight_pc", pc, 4);

    // restart from halt with a 3-cycle ROM latency: one load per fetch
    load_count = 0;
    applyStimulus(1'b1, 3, 1'b0);
    repeat (3) applyStimulus(1'b0, 3, 1'b0);
    checkOutput("wait_no_early_load", load_count, 0);
    applyStimulus(1'b0, 3, 1'b0);
    checkOutput("wait_single_load", load_count, 1);
    repeat (12) applyStimulus(1'b0, 3, 1'b1);

    // random program, latency, backpressure, branches (often to 0xFF), restarts
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[255] = {4'h2, 12'($urandom)};
    repeat (3000) applyStimulus($urandom_range(0, 7) == 0, -1, 1'b1);

    // asynchronous reset in the middle of a fetch
    for (int i = 0; i < 100 && phase != 1; i++) applyStimulus(1'b1, 2, 1'b1);
    checkOutput("reach_fetch", bus.rom_req, 1);
    @(posedge clk);
    #2;
    bus.rom_ack = 1'b1;
    rstn = 1'b0;
    #1;
    checkOutput("async_rom_req", bus.rom_req, 0);
    checkOutput("async_ir_load", bus.ir_load, 0);
    checkOutput("async_valid", bus.instr_valid, 0);
    checkOutput("async_halted", halted, 0);
    checkOutput("async_pc", pc, 0);
    bus.rom_ack = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    modelReset();
    applyStimulus(1'b1, 1, 1'b1);
    repeat (20) applyStimulus(1'b0, 1, 1'b1);

`ifdef FETCH_SEQ_TIMEOUT_EN
    // watchdog: never acknowledge, expect fault and halt after TIMEOUT waits
    applyReset();
    @(negedge clk);
    start       = 1'b1;
    bus.rom_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      checkOutput("wd_req_held", bus.rom_req, 1);
      checkOutput("wd_no_fault", fault, 0);
      @(negedge clk);
    end
    #1;
    checkOutput("wd_fault", fault, 1);
    checkOutput("wd_halted", halted, 1);
    checkOutput("wd_req_drop", bus.rom_req, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("wd_fault_clear", fault, 0);
    checkOutput("wd_halt_clear", halted, 0);
    checkOutput("wd_refetch_req", bus.rom_req, 1);
    checkOutput("wd_refetch_addr", bus.rom_addr, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
